// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA/DVI pixel path.
package vga_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
    localparam int PIX_W        = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } prefetch_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// rdata whenever the FIFO is non-empty; rdata reads as zero when empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_pop;

    // Status flags, head data and qualified read/write strobes
    always_comb begin
        empty  = (count == '0);
        full   = (count == FULL_CNT);
        do_pop = rd_en && !empty;
        // a write while full is only safe when the head is leaving this cycle
        do_wr  = wr_en && (!full || do_pop);
        rdata  = empty ? '0 : mem[rd_ptr];
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array, no reset needed since reads are gated by empty
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/frame_prefetch.sv
// Raster-order frame fetcher feeding the timing generator through a FWFT FIFO.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no requests; address parked at 0; waits for enable
//   FETCH | issue requests while outstanding + buffered < DEPTH
//   DRAIN | enable dropped; no requests; wait for outstanding returns
module frame_prefetch #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 19
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [vga_pkg::PIX_W-1:0] mem_rdata,
    input  logic                      rd_en,
    output logic [vga_pkg::PIX_W-1:0] fifo,
    output logic                      empty,
    output logic                      frame_start,
    output logic                      underflow
);

    import vga_pkg::*;

    localparam int CNT_W     = $clog2(DEPTH) + 1;
    localparam int FRAME_LEN = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_LEN - 1);
    localparam logic [CNT_W:0]    CREDIT_MAX = (CNT_W+1)'(DEPTH);

    prefetch_state_t  state;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic [CNT_W:0]   credit_used;
    logic             accept;

    // Request only with a guaranteed FIFO slot for every return in flight;
    // depends on registered state only, never on gnt/rvalid/rd_en
    always_comb begin
        credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
        mem_req     = (state == FETCH) && !fifo_full && (credit_used < CREDIT_MAX);
        accept      = mem_req && mem_gnt;
    end

    // Sequencing FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (enable) state <= FETCH;
                FETCH:   if (!enable) state <= DRAIN;
                DRAIN:   if (outstanding == '0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Requests accepted but not yet returned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({accept, mem_rvalid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Linear pixel address; wraps at frame end, parks at 0 when drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr <= '0;
        end else if (state == DRAIN && outstanding == '0) begin
            mem_addr <= '0;
        end else if (accept) begin
            mem_addr <= (mem_addr == LAST_ADDR) ? '0 : mem_addr + 1'b1;
        end
    end

    // Frame-start pulse and sticky underflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            frame_start <= accept && (mem_addr == '0);
            if (rd_en && empty) underflow <= 1'b1;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (PIX_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (mem_rvalid),
        .wdata (mem_rdata),
        .rd_en (rd_en),
        .rdata (fifo),
        .empty (empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_frame_prefetch.sv
// Directed bench for frame_prefetch on a reduced 8x4 frame.
module tb_frame_prefetch;

    localparam int FRAME = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [23:0]   mem_rdata;
    logic          rd_en;
    logic [23:0]   fifo;
    logic          empty;
    logic          frame_start;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    // memory/consumer agent state
    int cyc = 0;
    bit gnt_rand;
    int lat_min, lat_max;
    int pop_mode;
    int pend_addr[$];
    int pend_due[$];
    int exp_q[$];
    int occ;
    bit exp_uf;
    bit acc_prev;
    int acc_prev_addr;
    int exp_addr;
    int last_due;
    int acc_total, pop_total, fs_total, wraps;
    bit started;

    frame_prefetch #(
        .H_ACTIVE (8),
        .V_ACTIVE (4),
        .DEPTH    (DEPTH),
        .ADDR_W   (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .rd_en       (rd_en),
        .fifo        (fifo),
        .empty       (empty),
        .frame_start (frame_start),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pix(input int a);
        return 24'hC00000 | 24'(a);
    endfunction

    // Memory responder and pixel consumer, acting on every falling edge
    initial begin : agent
        bit wr, pop, acc, exp_fs;
        int lat, due;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 24'h0; rd_en = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst === 1'b1) begin
                pend_addr.delete(); pend_due.delete(); exp_q.delete();
                occ = 0; exp_uf = 0; acc_prev = 0; acc_prev_addr = 0; exp_addr = 0; last_due = 0;
                acc_total = 0; pop_total = 0; fs_total = 0; wraps = 0; started = 0;
                mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 24'h0; rd_en = 1'b0;
            end else begin
                checks++;
                if (empty !== (occ == 0))
                    begin errors++; $display("FAIL agent_empty: got %b expected %b cycle %0d", empty, occ == 0, cyc); end
                if (occ == 0) begin
                    checks++;
                    if (fifo !== 24'h0)
                        begin errors++; $display("FAIL agent_fifo_zero: got %h expected 0 cycle %0d", fifo, cyc); end
                end
                checks++;
                if (underflow !== exp_uf)
                    begin errors++; $display("FAIL agent_underflow: got %b expected %b cycle %0d", underflow, exp_uf, cyc); end
                exp_fs = acc_prev && (acc_prev_addr == 0);
                checks++;
                if (frame_start !== exp_fs)
                    begin errors++; $display("FAIL agent_frame_start: got %b expected %b cycle %0d", frame_start, exp_fs, cyc); end
                if (frame_start === 1'b1) fs_total++;
                if (mem_req === 1'b1) begin
                    checks++;
                    if (pend_addr.size() + occ >= DEPTH)
                        begin errors++; $display("FAIL agent_credit: got %0d in use expected < %0d cycle %0d", pend_addr.size() + occ, DEPTH, cyc); end
                end
                // return path
                wr = 1'b0;
                if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                    wr = 1'b1;
                    mem_rvalid = 1'b1;
                    mem_rdata = pix(pend_addr[0]);
                    exp_q.push_back(pend_addr[0]);
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end else begin
                    mem_rvalid = 1'b0;
                    mem_rdata = 24'h0;
                end
                // consumer
                case (pop_mode)
                    1: begin
                        if (empty === 1'b0) started = 1'b1;
                        rd_en = started;
                    end
                    2: rd_en = (empty === 1'b0) && ($urandom_range(1, 0) == 1);
                    3: rd_en = 1'b1;
                    default: rd_en = 1'b0;
                endcase
                pop = (rd_en === 1'b1) && (empty === 1'b0);
                if (pop) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL agent_pop_extra: got %h expected no data cycle %0d", fifo, cyc);
                    end else begin
                        if (fifo !== pix(exp_q[0]))
                            begin errors++; $display("FAIL agent_pixel: got %h expected %h cycle %0d", fifo, pix(exp_q[0]), cyc); end
                        void'(exp_q.pop_front());
                    end
                    pop_total++;
                end
                if (rd_en === 1'b1 && empty === 1'b1) exp_uf = 1'b1;
                // grant
                mem_gnt = gnt_rand ? 1'($urandom_range(1, 0)) : 1'b1;
                acc = (mem_req === 1'b1) && mem_gnt;
                acc_prev = acc;
                if (acc) begin
                    checks++;
                    if (mem_addr !== AW'(exp_addr))
                        begin errors++; $display("FAIL agent_addr: got %0d expected %0d cycle %0d", mem_addr, exp_addr, cyc); end
                    acc_prev_addr = exp_addr;
                    if (exp_addr == FRAME - 1) wraps++;
                    lat = int'($urandom_range(lat_max, lat_min));
                    due = cyc + lat;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    pend_addr.push_back(exp_addr);
                    pend_due.push_back(due);
                    exp_addr = (exp_addr + 1) % FRAME;
                    acc_total++;
                end
                occ = occ + int'(wr) - int'(pop);
                if (wr) begin
                    checks++;
                    if (occ > DEPTH)
                        begin errors++; $display("FAIL agent_overflow: got %0d entries expected <= %0d cycle %0d", occ, DEPTH, cyc); end
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst = 1'b1; enable = 1'b0; pop_mode = 0; gnt_rand = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        wait_cycles(2);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %0d expected 0", mem_addr); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (fifo !== 24'h0) begin errors++; $display("FAIL reset_fifo: got %h expected 0", fifo); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        apply_reset();
        lat_min = 3; lat_max = 3; pop_mode = 0;
        wait_cycles(1);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fill_idle_req: got %b expected 0", mem_req); end
        enable = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fill_req_before_edge: got %b expected 0", mem_req); end
        wait_cycles(1);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fill_first_req: got %b expected 1", mem_req); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL fill_first_addr: got %0d expected 0", mem_addr); end
        wait_cycles(40);
        checks++; if (acc_total != 16) begin errors++; $display("FAIL fill_req_count: got %0d expected 16", acc_total); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fill_req_stops: got %b expected 0", mem_req); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b expected 0", empty); end
        checks++; if (fifo !== 24'hC00000) begin errors++; $display("FAIL fill_head: got %h expected c00000", fifo); end
        checks++; if (mem_addr !== 5'd16) begin errors++; $display("FAIL fill_next_addr: got %0d expected 16", mem_addr); end
        checks++; if (fs_total != 1) begin errors++; $display("FAIL fill_frame_start: got %0d pulses expected 1", fs_total); end
        enable = 1'b0;
        wait_cycles(3);
    endtask

    task automatic test_stream();
        int t0, t1;
        bit done;
        apply_reset();
        lat_min = 3; lat_max = 3; pop_mode = 1;
        enable = 1'b1;
        t0 = -1; t1 = -1; done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            wait_cycles(1);
            if (t0 < 0 && pop_total >= 10) t0 = cyc;
            if (pop_total >= 10 + 2 * FRAME) begin t1 = cyc; done = 1'b1; end
        end
        checks++; if (!done) begin errors++; $display("FAIL stream_timeout: got %0d pixels expected %0d", pop_total, 10 + 2 * FRAME); end
        checks++; if (t1 - t0 != 2 * FRAME) begin errors++; $display("FAIL stream_rate: got %0d cycles expected %0d", t1 - t0, 2 * FRAME); end
        pop_mode = 2;
        enable = 1'b0;
        wait_cycles(40);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL stream_underflow: got %b expected 0", underflow); end
        checks++; if (pop_total != acc_total) begin errors++; $display("FAIL stream_delivered: got %0d expected %0d", pop_total, acc_total); end
        checks++; if (wraps < 2) begin errors++; $display("FAIL stream_wraps: got %0d expected >= 2", wraps); end
        checks++; if (fs_total != (acc_total + FRAME - 1) / FRAME)
            begin errors++; $display("FAIL stream_frames: got %0d expected %0d", fs_total, (acc_total + FRAME - 1) / FRAME); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_final_empty: got %b expected 1", empty); end
        pop_mode = 0;
    endtask

    task automatic test_underflow();
        apply_reset();
        wait_cycles(1);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_initial: got %b expected 0", underflow); end
        pop_mode = 3;
        wait_cycles(1);
        pop_mode = 0;
        wait_cycles(1);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b expected 1", underflow); end
        wait_cycles(5);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b expected 1", underflow); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL uf_empty: got %b expected 1", empty); end
        checks++; if (fifo !== 24'h0) begin errors++; $display("FAIL uf_fifo: got %h expected 0", fifo); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL uf_no_req: got %b expected 0", mem_req); end
        // pop in the very cycle the first pixel is written into an empty FIFO
        apply_reset();
        lat_min = 1; lat_max = 1;
        enable = 1'b1;
        wait_cycles(1);
        pop_mode = 3;
        wait_cycles(1);
        pop_mode = 0;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_wr_before: got %b expected 0", underflow); end
        wait_cycles(1);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_wr_same_cycle: got %b expected 1", underflow); end
        checks++; if (fifo !== 24'hC00000) begin errors++; $display("FAIL uf_wr_head: got %h expected c00000", fifo); end
        enable = 1'b0;
        wait_cycles(20);
    endtask

    task automatic test_random();
        bit done;
        apply_reset();
        gnt_rand = 1'b1; lat_min = 1; lat_max = 12; pop_mode = 2;
        enable = 1'b1;
        wait_cycles(600);
        enable = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            wait_cycles(1);
            if (pend_addr.size() == 0 && occ == 0 && mem_req === 1'b0) done = 1'b1;
        end
        checks++; if (!done) begin errors++; $display("FAIL rand_drain_timeout: got %0d left expected 0", pend_addr.size() + occ); end
        checks++; if (pop_total != acc_total) begin errors++; $display("FAIL rand_delivered: got %0d expected %0d", pop_total, acc_total); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL rand_underflow: got %b expected 0", underflow); end
        checks++; if (pop_total <= FRAME) begin errors++; $display("FAIL rand_volume: got %0d expected > %0d", pop_total, FRAME); end
        gnt_rand = 1'b0; pop_mode = 0;
    endtask

    task automatic test_drain();
        bit done;
        apply_reset();
        lat_min = 8; lat_max = 8; pop_mode = 0;
        enable = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            wait_cycles(1);
            if (acc_total == 5) begin enable = 1'b0; done = 1'b1; end
        end
        checks++; if (!done) begin errors++; $display("FAIL drain_setup: got %0d requests expected 5", acc_total); end
        wait_cycles(20);
        checks++; if (acc_total != 5) begin errors++; $display("FAIL drain_no_new_req: got %0d expected 5", acc_total); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL drain_req_low: got %b expected 0", mem_req); end
        checks++; if (fifo !== 24'hC00000) begin errors++; $display("FAIL drain_head: got %h expected c00000", fifo); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL drain_idle_addr: got %0d expected 0", mem_addr); end
        pop_mode = 2;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            wait_cycles(1);
            if (pop_total >= 5) done = 1'b1;
        end
        pop_mode = 0;
        wait_cycles(2);
        checks++; if (pop_total != 5) begin errors++; $display("FAIL drain_landed: got %0d expected 5", pop_total); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
        exp_addr = 0;
        enable = 1'b1;
        wait_cycles(2);
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL drain_restart_fs: got %b expected 1", frame_start); end
        checks++; if (mem_addr !== 5'd1) begin errors++; $display("FAIL drain_restart_addr: got %0d expected 1", mem_addr); end
        enable = 1'b0;
        wait_cycles(30);
    endtask

    task automatic test_rst_mid();
        bit done;
        apply_reset();
        lat_min = 3; lat_max = 3; pop_mode = 0;
        enable = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            wait_cycles(1);
            if (occ >= 8) done = 1'b1;
        end
        checks++; if (!done) begin errors++; $display("FAIL rstmid_setup: got %0d entries expected 8", occ); end
        rst = 1'b1;
        enable = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_mem_req: got %b expected 0", mem_req); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL rstmid_mem_addr: got %0d expected 0", mem_addr); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b expected 1", empty); end
        checks++; if (fifo !== 24'h0) begin errors++; $display("FAIL rstmid_fifo: got %h expected 0", fifo); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rstmid_frame_start: got %b expected 0", frame_start); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL rstmid_underflow: got %b expected 0", underflow); end
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(3);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_after_empty: got %b expected 1", empty); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_after_req: got %b expected 0", mem_req); end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; gnt_rand = 1'b0; lat_min = 3; lat_max = 3; pop_mode = 0;
        test_reset();
        test_fill();
        test_stream();
        test_underflow();
        test_random();
        test_drain();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
